board_move_arbiter: RTL and testbench

Shares the single write port of the board RAM between several sprite movers (Pac-Man, ghosts) so each move is one atomic transaction: clear the old cell, then draw the sprite in the new cell. It sits between the movement/behaviour blocks and the board RAM write port (`wren`, `wraddress`, `data`). It replaces per-mover write sequencing with one round-robin scheduler whose write latency is fixed.

---
 rtl/board_move_arbiter.sv | 154 +++++++++++++++
 tb/tb_board_move_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_move_arbiter.sv
// Round-robin owner of the board RAM write port: each granted move clears the
// old cell, draws the sprite in the new cell and pulses done, in a fixed four-cycle slot.
module board_move_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4,
    parameter int CELLS  = 768
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   old_addr,
    input  logic [NREQ*ADDR_W-1:0]   new_addr,
    input  logic [NREQ*DATA_W-1:0]   bg_code,
    input  logic [NREQ*DATA_W-1:0]   sprite_code,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy,
    output logic                     wren,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W:0]  NREQ_W  = (PTR_W+1)'(NREQ);
    localparam logic [31:0]     CELLS_U = 32'(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        WR_OLD,
        WR_NEW,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  win_reg;
    logic [ADDR_W-1:0] old_reg, new_reg;
    logic [DATA_W-1:0] bg_reg, sprite_reg;

    logic [ADDR_W-1:0] old_arr    [NREQ];
    logic [ADDR_W-1:0] new_arr    [NREQ];
    logic [DATA_W-1:0] bg_arr     [NREQ];
    logic [DATA_W-1:0] sprite_arr [NREQ];
    logic [PTR_W-1:0]  cand_idx   [NREQ];
    logic [NREQ-1:0]   rot_req;

    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic              old_ok, new_ok;

    // cand_idx[k] is the requester k places after ptr, wrapped modulo NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            logic [PTR_W:0] sum_raw;

            assign old_arr[gi]    = old_addr[gi*ADDR_W +: ADDR_W];
            assign new_arr[gi]    = new_addr[gi*ADDR_W +: ADDR_W];
            assign bg_arr[gi]     = bg_code[gi*DATA_W +: DATA_W];
            assign sprite_arr[gi] = sprite_code[gi*DATA_W +: DATA_W];

            assign sum_raw      = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum_raw >= NREQ_W) ? PTR_W'(sum_raw - NREQ_W)
                                                       : PTR_W'(sum_raw);
            assign rot_req[gi]  = req[cand_idx[gi]];

            assign done[gi] = (state_reg == DONE) && (win_reg == PTR_W'(gi));
        end
    endgenerate

    // Lowest rotated position wins, so the descending loop keeps the first hit.
    always_comb begin
        grant_valid = |req;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant_idx = cand_idx[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_reg    <= '0;
            old_reg    <= '0;
            new_reg    <= '0;
            bg_reg     <= '0;
            sprite_reg <= '0;
        end else if (state_reg == IDLE && grant_valid) begin
            win_reg    <= grant_idx;
            old_reg    <= old_arr[grant_idx];
            new_reg    <= new_arr[grant_idx];
            bg_reg     <= bg_arr[grant_idx];
            sprite_reg <= sprite_arr[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (state_reg == DONE) begin
            ptr_reg <= (win_reg == PTR_W'(NREQ - 1)) ? '0 : win_reg + PTR_W'(1);
        end
    end

    assign old_ok = 32'(old_reg) < CELLS_U;
    assign new_ok = 32'(new_reg) < CELLS_U;

    always_comb begin
        state_next = state_reg;
        wren       = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        err        = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = WR_OLD;
                end
            end
            WR_OLD: begin
                // Clearing a cell the sprite is about to occupy would only flicker it.
                wren       = old_ok && (old_reg != new_reg);
                wr_addr    = old_reg;
                wr_data    = bg_reg;
                state_next = WR_NEW;
            end
            WR_NEW: begin
                wren       = new_ok;
                wr_addr    = new_reg;
                wr_data    = sprite_reg;
                state_next = DONE;
            end
            DONE: begin
                err        = !(old_ok && new_ok);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_board_move_arbiter.sv
// Randomised bench for board_move_arbiter: a cycle-level reference model of the
// requesters and arbitration rules fills a scoreboard that a monitor drains.
module tb_board_move_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;
    localparam int CELLS  = 768;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] old_addr = '0;
    logic [NREQ*ADDR_W-1:0] new_addr = '0;
    logic [NREQ*DATA_W-1:0] bg_code = '0;
    logic [NREQ*DATA_W-1:0] sprite_code = '0;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic                   busy;
    logic                   wren;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;

    board_move_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .old_addr(old_addr), .new_addr(new_addr),
        .bg_code(bg_code), .sprite_code(sprite_code),
        .done(done), .err(err), .busy(busy),
        .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        int addr;
        int data;
        int idx;
        bit err;
    } ev_t;

    ev_t evq[$];
    bit  exp_busy[int];
    int  checks = 0;
    int  failures = 0;

    // Reference model of the requesters and the arbiter's externally visible schedule.
    bit pend[NREQ];
    bit inflight[NREQ];
    int done_cyc[NREQ];
    int p_old[NREQ], p_new[NREQ], p_bg[NREQ], p_sp[NREQ];
    int mptr = 0;
    int next_free = 0;
    bit mode_random = 0;
    bit keep_busy = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) < 2) return int'($urandom_range(CELLS, 1023));
        return int'($urandom_range(0, CELLS - 1));
    endfunction

    task automatic post(int i, int o, int n, int b, int s);
        pend[i]  = 1'b1;
        p_old[i] = o;
        p_new[i] = n;
        p_bg[i]  = b;
        p_sp[i]  = s;
    endtask

    task automatic post_rand(int i);
        int o, n;
        o = rand_addr();
        n = ($urandom_range(0, 7) == 0) ? o : rand_addr();
        post(i, o, n, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle of stimulus: requester behaviour, optional reset, and the model's grant.
    task automatic step(bit do_rst);
        int c, w, idx;
        ev_t e;
        ev_t keep[$];
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < NREQ; i++) begin
            if (inflight[i] && done_cyc[i] == c) begin
                inflight[i] = 1'b0;
                pend[i]     = 1'b0;
                if (keep_busy) post_rand(i);
            end
        end
        if (mode_random) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) post_rand(i);
        end
        if (do_rst) begin
            reset = 1'b1;
            for (int i = 0; i < NREQ; i++) inflight[i] = 1'b0;
            foreach (evq[j]) if (evq[j].cyc <= c) keep.push_back(evq[j]);
            evq = keep;
            for (int d = 1; d <= 3; d++) exp_busy[c + d] = 1'b0;
            mptr      = 0;
            next_free = c + 1;
        end else begin
            reset = 1'b0;
        end
        // A granted requester's inputs are free to change; the arbiter must not notice.
        for (int i = 0; i < NREQ; i++) begin
            if (inflight[i]) begin
                p_old[i] = int'($urandom_range(0, 1023));
                p_new[i] = int'($urandom_range(0, 1023));
                p_bg[i]  = int'($urandom_range(0, 15));
                p_sp[i]  = int'($urandom_range(0, 15));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = pend[i];
            old_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'(p_old[i]);
            new_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'(p_new[i]);
            bg_code[i*DATA_W +: DATA_W]     = DATA_W'(p_bg[i]);
            sprite_code[i*DATA_W +: DATA_W] = DATA_W'(p_sp[i]);
        end
        if (!do_rst && c >= next_free) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (w < 0 && pend[idx]) w = idx;
            end
            if (w >= 0) begin
                if (p_old[w] != p_new[w] && p_old[w] < CELLS) begin
                    e = '{cyc: c + 1, is_done: 1'b0, addr: p_old[w], data: p_bg[w], idx: w, err: 1'b0};
                    evq.push_back(e);
                end
                if (p_new[w] < CELLS) begin
                    e = '{cyc: c + 2, is_done: 1'b0, addr: p_new[w], data: p_sp[w], idx: w, err: 1'b0};
                    evq.push_back(e);
                end
                e = '{cyc: c + 3, is_done: 1'b1, addr: 0, data: 0, idx: w,
                      err: (p_old[w] >= CELLS) || (p_new[w] >= CELLS)};
                evq.push_back(e);
                for (int d = 1; d <= 3; d++) exp_busy[c + d] = 1'b1;
                inflight[w] = 1'b1;
                done_cyc[w] = c + 3;
                next_free   = c + 4;
                mptr        = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic run_idle(int max_cycles);
        int n = 0;
        while (any_pend() && n < max_cycles) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (any_pend()) begin
            failures++;
            $display("FAIL drain_timeout cycle=%0d got=pending expected=idle within %0d cycles", cyc, max_cycles);
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard entry due then.
    initial begin
        int  k, exp_done, exp_err, exp_wren, exp_b;
        bit  zero_bus;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            k        = cyc;
            exp_done = 0;
            exp_err  = 0;
            exp_wren = 0;
            exp_b    = (exp_busy.exists(k) && exp_busy[k]) ? 1 : 0;
            zero_bus = (exp_b == 0);
            e        = '{cyc: 0, is_done: 1'b0, addr: 0, data: 0, idx: 0, err: 1'b0};
            while (evq.size() > 0 && evq[0].cyc < k) begin
                e = evq.pop_front();
                chk("stale_event", k, e.cyc);
            end
            if (evq.size() > 0 && evq[0].cyc == k) begin
                e = evq.pop_front();
                if (e.is_done) begin
                    exp_done = 1 << e.idx;
                    exp_err  = e.err ? 1 : 0;
                    zero_bus = 1'b1;
                end else begin
                    exp_wren = 1;
                end
            end
            chk("busy", int'(busy), exp_b);
            chk("wren", int'(wren), exp_wren);
            chk("done", int'(done), exp_done);
            chk("err", int'(err), exp_err);
            if (exp_wren != 0) begin
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
            end else if (zero_bus) begin
                chk("idle_wr_addr", int'(wr_addr), 0);
                chk("idle_wr_data", int'(wr_data), 0);
            end
            if (done != '0 || exp_done != 0)
                $display("txn cycle=%0d done=%b err=%0d expected_requester=%0d", k, done, err, e.idx);
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; inflight[i] = 0; done_cyc[i] = 0;
            p_old[i] = 0; p_new[i] = 0; p_bg[i] = 0; p_sp[i] = 0;
        end
        repeat (3) step(1'b1);

        // Single move on requester 0.
        post(0, 495, 496, 0, 3);
        run_idle(20);

        // Every requester kept asserted from reset: strict 0,1,2,3 rotation.
        step(1'b1);
        for (int i = 0; i < NREQ; i++) post_rand(i);
        keep_busy = 1'b1;
        repeat (32) step(1'b0);
        keep_busy = 1'b0;
        run_idle(40);

        // Pointer wrap: serve 2 alone, then 0 and 3 together.
        step(1'b1);
        post(2, 40, 41, 0, 6);
        run_idle(20);
        post(0, 50, 51, 0, 7);
        post(3, 60, 61, 1, 8);
        run_idle(30);

        // Stationary sprite and out-of-range old cell.
        post(1, 100, 100, 2, 5);
        run_idle(20);
        post(3, 800, 10, 0, 7);
        run_idle(20);
        post(0, 5, 900, 0, 9);
        run_idle(20);

        // Reset in WR_NEW, then the same request is served again from ptr 0.
        post(2, 300, 301, 0, 4);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        post(1, 200, 201, 0, 2);
        run_idle(30);

        mode_random = 1'b1;
        repeat (3000) step($urandom_range(0, 299) == 0);
        mode_random = 1'b0;
        run_idle(100);
        repeat (4) step(1'b0);
        chk("scoreboard_empty", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
